// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, digit-box geometry, colours and the
// segment-rectangle helper used by vga_digit.
package vga_pkg;

  localparam logic [9:0] H_VISIBLE = 10'd640;
  localparam logic [9:0] H_FRONT   = 10'd16;
  localparam logic [9:0] H_SYNC    = 10'd96;
  localparam logic [9:0] H_BACK    = 10'd48;
  localparam logic [9:0] H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] V_FRONT   = 10'd10;
  localparam logic [9:0] V_SYNC    = 10'd2;
  localparam logic [9:0] V_BACK    = 10'd33;
  localparam logic [9:0] V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_SYNC_FIRST = H_VISIBLE + H_FRONT;
  localparam logic [9:0] H_SYNC_LAST  = H_SYNC_FIRST + H_SYNC - 10'd1;
  localparam logic [9:0] V_SYNC_FIRST = V_VISIBLE + V_FRONT;
  localparam logic [9:0] V_SYNC_LAST  = V_SYNC_FIRST + V_SYNC - 10'd1;

  localparam logic [9:0] SEG_T = 10'd16;
  localparam logic [9:0] BOX_W = 10'd96;
  localparam logic [9:0] BOX_H = 10'd160;

  localparam logic [9:0] SEG_X_IN_END = BOX_W - SEG_T - 10'd1;
  localparam logic [9:0] SEG_X_RIGHT  = BOX_W - SEG_T;
  localparam logic [9:0] SEG_Y_MID    = (BOX_H / 10'd2) - (SEG_T / 10'd2);
  localparam logic [9:0] SEG_Y_MID_E  = SEG_Y_MID + SEG_T - 10'd1;
  localparam logic [9:0] SEG_Y_BOT    = BOX_H - SEG_T;

  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] RED   = 3'b100;

  function automatic logic in_rng(input logic [9:0] v, input logic [9:0] lo,
                                  input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Which segment rectangles {a..g} contain local point (lx, ly).
  function automatic logic [6:0] seg_hits(input logic [9:0] lx, input logic [9:0] ly);
    logic [6:0] h;
    h[6] = in_rng(ly, 10'd0, SEG_T - 10'd1) && in_rng(lx, SEG_T, SEG_X_IN_END);
    h[5] = in_rng(lx, SEG_X_RIGHT, BOX_W - 10'd1) && in_rng(ly, SEG_T, SEG_Y_MID - 10'd1);
    h[4] = in_rng(lx, SEG_X_RIGHT, BOX_W - 10'd1) && in_rng(ly, SEG_Y_MID_E + 10'd1, SEG_Y_BOT - 10'd1);
    h[3] = in_rng(ly, SEG_Y_BOT, BOX_H - 10'd1) && in_rng(lx, SEG_T, SEG_X_IN_END);
    h[2] = in_rng(lx, 10'd0, SEG_T - 10'd1) && in_rng(ly, SEG_Y_MID_E + 10'd1, SEG_Y_BOT - 10'd1);
    h[1] = in_rng(lx, 10'd0, SEG_T - 10'd1) && in_rng(ly, SEG_T, SEG_Y_MID - 10'd1);
    h[0] = in_rng(ly, SEG_Y_MID, SEG_Y_MID_E) && in_rng(lx, SEG_T, SEG_X_IN_END);
    return h;
  endfunction

endpackage

// File: rtl/vga_digit_if.sv
// Digit-in / VGA-out signal bundle for vga_digit; the design takes the slave view.
interface vga_digit_if;
  logic [3:0] num;
  logic       vgae2;
  logic       hsync;
  logic       vsync;
  logic [2:0] rgb;

  modport master (output num, output vgae2, input hsync, input vsync, input rgb);
  modport slave  (input num, input vgae2, output hsync, output vsync, output rgb);
endinterface

// File: rtl/seg7_decode.sv
// Combinational digit to {a..g} segment mask; 15 shows "E", 10-14 are dark.
module seg7_decode (
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  // Standard 7-segment patterns, bit 6 = a down to bit 0 = g.
  always_comb begin
    seg_o = 7'b000_0000;
    case (digit_i)
      4'd0:    seg_o = 7'b111_1110;
      4'd1:    seg_o = 7'b011_0000;
      4'd2:    seg_o = 7'b110_1101;
      4'd3:    seg_o = 7'b111_1001;
      4'd4:    seg_o = 7'b011_0011;
      4'd5:    seg_o = 7'b101_1011;
      4'd6:    seg_o = 7'b101_1111;
      4'd7:    seg_o = 7'b111_0000;
      4'd8:    seg_o = 7'b111_1111;
      4'd9:    seg_o = 7'b111_1011;
      4'd15:   seg_o = 7'b100_1111;
      default: seg_o = 7'b000_0000;
    endcase
  end

endmodule

// File: rtl/vga_digit.sv
// 640x480@60 VGA generator drawing one frame-latched 7-segment digit.
// Define VGA_CLKDIV_EN to derive the pixel tick from a 2:1 divider of clk.
module vga_digit
  import vga_pkg::*;
#(
  parameter int DIGIT_X = 272,
  parameter int DIGIT_Y = 160
) (
  input  logic        clk,
  input  logic        reset,
  vga_digit_if.slave  bus
);

  localparam logic [10:0] BOX_X0 = 11'(DIGIT_X);
  localparam logic [10:0] BOX_X1 = BOX_X0 + {1'b0, BOX_W};
  localparam logic [10:0] BOX_Y0 = 11'(DIGIT_Y);
  localparam logic [10:0] BOX_Y1 = BOX_Y0 + {1'b0, BOX_H};

  logic       tick_s;
  logic [9:0] hc_q, hc_d, vc_q, vc_d;
  logic [3:0] num_q, num_d;
  logic       en_q, en_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic [2:0] rgb_q, rgb_d;
  logic [6:0] seg_mask_s;
  logic [2:0] colour_s;
  logic [9:0] lx_s, ly_s;
  logic       in_box_s, visible_s, lit_s, frame_end_s;

`ifdef VGA_CLKDIV_EN
  logic div_q;

  // Divider starts at 0 so the first tick lands on the second edge after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= 1'b0;
    end else begin
      div_q <= ~div_q;
    end
  end

  assign tick_s = div_q;
`else
  assign tick_s = 1'b1;
`endif

  seg7_decode u_seg7_decode (
    .digit_i (num_q),
    .seg_o   (seg_mask_s)
  );

  assign frame_end_s = (hc_q == H_TOTAL - 10'd1) && (vc_q == V_TOTAL - 10'd1);

  // Raster counters and the frame latch advance only on pixel ticks.
  always_comb begin
    hc_d  = hc_q;
    vc_d  = vc_q;
    num_d = num_q;
    en_d  = en_q;
    if (tick_s) begin
      if (hc_q == H_TOTAL - 10'd1) begin
        hc_d = 10'd0;
        if (vc_q == V_TOTAL - 10'd1) begin
          vc_d = 10'd0;
        end else begin
          vc_d = vc_q + 10'd1;
        end
      end else begin
        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
      end
      if (frame_end_s) begin
        num_d = bus.num;
        en_d  = bus.vgae2;
      end else begin
        num_d = num_q;
        en_d  = en_q;
      end
    end else begin
      hc_d  = hc_q;
      vc_d  = vc_q;
      num_d = num_q;
      en_d  = en_q;
    end
  end

  assign in_box_s  = ({1'b0, hc_q} >= BOX_X0) && ({1'b0, hc_q} < BOX_X1) &&
                     ({1'b0, vc_q} >= BOX_Y0) && ({1'b0, vc_q} < BOX_Y1);
  assign lx_s      = hc_q - BOX_X0[9:0];
  assign ly_s      = vc_q - BOX_Y0[9:0];
  assign visible_s = (hc_q < H_VISIBLE) && (vc_q < V_VISIBLE);
  assign lit_s     = in_box_s && (|(seg_hits(lx_s, ly_s) & seg_mask_s));
  assign colour_s  = (num_q == 4'd15) ? RED : GREEN;

  // Output stage: sync and colour for the current counter value, registered together.
  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    rgb_d   = rgb_q;
    if (tick_s) begin
      hsync_d = !((hc_q >= H_SYNC_FIRST) && (hc_q <= H_SYNC_LAST));
      vsync_d = !((vc_q >= V_SYNC_FIRST) && (vc_q <= V_SYNC_LAST));
      if (visible_s && en_q && lit_s) begin
        rgb_d = colour_s;
      end else begin
        rgb_d = 3'b000;
      end
    end else begin
      hsync_d = hsync_q;
      vsync_d = vsync_q;
      rgb_d   = rgb_q;
    end
  end

  // State register with asynchronous reset to the idle raster position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hc_q    <= 10'd0;
      vc_q    <= 10'd0;
      num_q   <= 4'd0;
      en_q    <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= 3'b000;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      num_q   <= num_d;
      en_q    <= en_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign bus.hsync = hsync_q;
  assign bus.vsync = vsync_q;
  assign bus.rgb   = rgb_q;

endmodule

// File: tb/tb_vga_digit.sv
// Directed bench for vga_digit: tracks the raster position itself and checks
// {hsync, vsync, rgb} at chosen pixels across several frames and a mid-frame reset.
module tb_vga_digit;

  localparam logic [4:0] IDLE  = 5'b11_000;
  localparam logic [4:0] GRN   = 5'b11_010;
  localparam logic [4:0] REDPX = 5'b11_100;
  localparam logic [4:0] HS_LO = 5'b01_000;
  localparam logic [4:0] VS_LO = 5'b10_000;
  localparam logic [4:0] HV_LO = 5'b00_000;
  localparam int GUARD = 450000;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail = 0;
  int   nx = 0;
  int   ny = 0;
  int   sx = 0;
  int   sy = 0;

  vga_digit_if bus ();

  vga_digit #(.DIGIT_X(272), .DIGIT_Y(160)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {bus.hsync, bus.vsync, bus.rgb};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s pixel (%0d,%0d): hs/vs/rgb observed %b expected %b", tag, sx, sy, obs, exp);
    end
  endtask

  // One pixel tick; afterwards the outputs show pixel (sx, sy).
  task automatic step();
`ifdef VGA_CLKDIV_EN
    @(posedge clk);
`endif
    @(posedge clk);
    #1;
    sx = nx;
    sy = ny;
    if (nx == 799) begin
      nx = 0;
      ny = (ny == 524) ? 0 : ny + 1;
    end else begin
      nx = nx + 1;
    end
  endtask

  task automatic run_to(input int x, input int y);
    int guard;
    guard = 0;
    while (!(nx == x && ny == y) && guard < GUARD) begin
      step();
      guard++;
    end
    if (guard >= GUARD) begin
      n_fail++;
      $error("FAIL run_to timeout: target (%0d,%0d) not reached", x, y);
    end
    step();
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    nx = 0;
    ny = 0;
  endtask

  initial begin
    reset     = 1'b1;
    bus.num   = 4'd0;
    bus.vgae2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", IDLE);
    release_reset();

    // Frame A: latched enable is still 0 from reset.
    bus.num   = 4'd8;
    bus.vgae2 = 1'b1;
    run_to(0, 0);     chk("first_pixel", IDLE);
    run_to(655, 0);   chk("hsync_before_fall", IDLE);
    run_to(656, 0);   chk("hsync_fall", HS_LO);
    run_to(751, 0);   chk("hsync_last_low", HS_LO);
    run_to(752, 0);   chk("hsync_rise", IDLE);
    run_to(655, 1);   chk("line2_before_fall", IDLE);
    run_to(656, 1);   chk("line2_hsync_fall", HS_LO);
    run_to(320, 240); chk("latched_enable_off", IDLE);
    run_to(799, 489); chk("vsync_before_fall", IDLE);
    run_to(0, 490);   chk("vsync_fall", VS_LO);
    run_to(700, 491); chk("both_sync_low", HV_LO);
    run_to(0, 492);   chk("vsync_rise", IDLE);

    // Frame B: digit 8 in green.
    run_to(280, 200); chk("eight_seg_f", GRN);
    run_to(320, 200); chk("eight_upper_gap", IDLE);
    run_to(700, 200); chk("right_of_visible", HS_LO);
    run_to(271, 260); chk("left_of_box", IDLE);
    run_to(272, 260); chk("eight_seg_e_edge", GRN);
    run_to(320, 240); chk("eight_seg_g", GRN);
    run_to(0, 300);
    bus.num = 4'd15;
    run_to(320, 310); chk("midframe_change_held", GRN);
    run_to(799, 489); chk("frame2_vsync_high", IDLE);
    run_to(0, 490);   chk("frame_period_vsync", VS_LO);

    // Frame C: error "E" in red.
    run_to(320, 165); chk("err_seg_a", REDPX);
    run_to(360, 200); chk("err_seg_b_off", IDLE);
    run_to(300, 240); chk("err_seg_g", REDPX);
    run_to(360, 260); chk("err_seg_c_off", IDLE);
    run_to(320, 310); chk("err_seg_d", REDPX);

    // Mid-frame reset with display disabled afterwards.
    bus.num   = 4'd8;
    bus.vgae2 = 1'b0;
    run_to(399, 250);
    reset = 1'b1;
    #1;
    chk("reset_async", IDLE);
    repeat (4) @(posedge clk);
    #1;
    chk("reset_hold", IDLE);
    release_reset();
    run_to(0, 0);     chk("restart_pixel", IDLE);
    run_to(656, 0);   chk("restart_hsync_fall", HS_LO);
    run_to(320, 240); chk("disabled_blank", IDLE);
    run_to(799, 489); chk("restart_vsync_high", IDLE);
    run_to(0, 490);   chk("restart_vsync_fall", VS_LO);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
